spi_flash_cmd_sequencer: RTL
============================

Name: spi_flash_cmd_sequencer

Overview:
Command-level controller for the external QSPI/SPI NOR flash. It accepts one host request at a time: read, page program, sector erase, 32k/64k block erase, or status read. It expands each request into the full flash transaction sequence: write-enable, opcode, 24-bit address, data phase, chip-select gaps and busy polling. It drives an external byte-level SPI shifter through a start/done handshake and owns ncs directly.

Parameters:
CS_GAP, 4, minimum clk cycles ncs held high between frames (>=1)
POLL_GAP, 16, clk cycles between status polls while BUSY=1
POLL_MAX, 65535, maximum status polls before timeout error (16-bit)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer idle, request accepted when valid&ready
req_op  in  3  0=READ 03h, 1=PAGE_PROG 02h, 2=SECTOR_ERASE 20h, 3=BLK32 52h, 4=BLK64 D8h, 5=READ_STATUS 05h
req_addr  in  24  flash byte address
req_len  in  9  byte count for READ/PAGE_PROG, 1..256
wr_data  in  8  program data byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  wr_data consumed this cycle
rd_data  out  8  read byte (READ or READ_STATUS)
rd_valid  out  1  one-cycle pulse per rd_data byte
done  out  1  one-cycle pulse at request completion
err  out  1  valid with done: illegal request or poll timeout
ncs  out  1  flash chip select, active low
shf_start  out  1  one-cycle pulse, launch byte exchange
shf_tx  out  8  byte to shift out, held while shifter busy
shf_done  in  1  one-cycle pulse, exchange complete
shf_rx  in  8  received byte, valid with shf_done

Behaviour:
- Reset: state IDLE; req_ready=1, ncs=1; wr_ready, rd_valid, done, err, shf_start=0; rd_data, shf_tx=00h; all counters 0.
- Accept: in IDLE with req_valid=1, latch op/addr/len. req_ready drops the next cycle and returns high only on return to IDLE.
- Illegal: op 6/7; len=0 or len>256 for READ/PAGE_PROG. The request is dropped without any bus activity. done=1, err=1 one cycle after acceptance.
- shf_start fires only while ncs=0 and the shifter is idle, i.e. after the previous shf_done. Its earliest issue is the cycle after ncs falls. shf_tx is stable from shf_start until shf_done.
- States: IDLE, WREN, WREN_GAP, CMD, ADDR, DATA, END_GAP, POLL_CMD, POLL_RD, POLL_WAIT, DONE.
- WREN applies to PAGE_PROG and erases only. ncs=0, send 06h, ncs=1 on shf_done. Then WREN_GAP: hold ncs=1 for CS_GAP cycles.
- CMD: ncs=0, send the opcode. Go to ADDR, except READ_STATUS, which goes directly to DATA with len=1.
- ADDR: send addr[23:16], [15:8], [7:0] in that order.
- DATA, READ/READ_STATUS: send 00h len times. Each shf_done gives rd_data=shf_rx and rd_valid=1 in the same registered cycle.
- DATA, PAGE_PROG: per byte, wait for wr_valid. wr_ready=1 for exactly the cycle the byte is taken, and shf_start pulses the next cycle. If wr_valid stays low, the sequencer stalls with ncs low and no timeout.
- After the last byte (or after ADDR for erases): ncs=1, then END_GAP of CS_GAP cycles.
- READ and READ_STATUS go from END_GAP to DONE. PROG and erases go from END_GAP to POLL_CMD.
- POLL_CMD: ncs=0, send 05h. POLL_RD: send 00h. On shf_done, ncs=1 and the poll counter increments.
  - shf_rx[0]=0: DONE, err=0.
  - BUSY and poll count=POLL_MAX: DONE, err=1.
  - Otherwise POLL_WAIT: POLL_GAP cycles with ncs=1, then POLL_CMD.
- Poll bytes are not reported on rd_data.
- DONE: done=1 for one cycle, err valid, then IDLE with req_ready=1.
- Address arithmetic: none. The flash handles page wrap. PAGE_PROG crossing a 256-byte boundary wraps inside the page; this block does not check it.
- Reset mid-operation: ncs goes to 1 immediately (asynchronously) and all state is cleared. The partial flash command is abandoned.
- shf_done arriving while no exchange is outstanding is ignored.

Test Plan:
- READ addr=012345h len=3: the shifter model returns AAh, BBh, CCh. Required: ncs low frame carrying bytes 03h,01h,23h,45h,00h,00h,00h; rd_data AAh,BBh,CCh with 3 rd_valid pulses; done=1, err=0; no 06h sent.
- PAGE_PROG addr=000100h len=2, data 5Ah,A5h, status model BUSY for 3 polls. Required:
  - frame 06h, ncs high >=CS_GAP cycles;
  - frame 02h,00h,01h,00h,5Ah,A5h;
  - four 05h,00h poll frames separated by >=POLL_GAP;
  - done, err=0.
- SECTOR_ERASE with POLL_MAX=4 and status always 01h -> exactly 4 poll frames, then done=1, err=1.
- Illegal requests: op=7, then READ len=0, then PAGE_PROG len=257 -> each gives done+err one cycle after acceptance, ncs stays 1, shf_start never pulses.
- PAGE_PROG with wr_valid held low for 50 cycles after the address -> ncs stays 0, no shf_start, no done. Raising wr_valid resumes with the correct byte.
- rst_n asserted mid-DATA of a READ len=256 -> ncs=1 asynchronously, req_ready=1 after release. A following READ_STATUS returns one byte with done, err=0.

Source files
------------

// File: rtl/spi_flash_cmd_sequencer.sv
// SPI NOR flash command sequencer. Turns one host request into a complete flash
// transaction (write-enable, opcode, address, data, busy polling) driven over a
// byte-level SPI shifter through a start/done handshake. Owns chip select.
module spi_flash_cmd_sequencer #(
  parameter int CS_GAP   = 4,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [8:0]  req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic        ncs,
  output logic        shf_start,
  output logic [7:0]  shf_tx,
  input  logic        shf_done,
  input  logic [7:0]  shf_rx
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_GAP, S_CMD, S_ADDR, S_DATA, S_END_GAP,
    S_POLL_CMD, S_POLL_RD, S_POLL_WAIT, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_READ, OP_PROG, OP_SE, OP_BE32, OP_BE64, OP_RDSR
  } op_e;

  localparam logic [15:0] CS_LAST   = 16'(CS_GAP - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIM  = 16'(POLL_MAX);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;     // bytes completed in the current phase
  logic [15:0] gap_q, gap_d;     // ncs-high cycles spent in a gap state
  logic [15:0] poll_q, poll_d;   // status polls issued for this request
  logic        pend_q, pend_d;   // byte exchange outstanding on the shifter
  logic        ncs_q, ncs_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic send_state, can_issue, xfer_done, req_legal, req_writes, is_erase, is_read;

  function automatic logic [7:0] opcode(input op_e op);
    case (op)
      OP_READ: return 8'h03;
      OP_PROG: return 8'h02;
      OP_SE:   return 8'h20;
      OP_BE32: return 8'h52;
      OP_BE64: return 8'hD8;
      default: return 8'h05;
    endcase
  endfunction

  assign send_state = (state_q == S_WREN) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DATA) || (state_q == S_POLL_CMD) || (state_q == S_POLL_RD);
  // A new byte may launch only inside a low-ncs frame with the shifter idle.
  assign can_issue  = send_state && !ncs_q && !pend_q && !start_q;
  // A done pulse with nothing outstanding is stray and ignored.
  assign xfer_done  = shf_done && pend_q && !start_q;
  assign req_legal  = (req_op <= 3'd5) &&
                      ((req_op > 3'd1) || ((req_len != 9'd0) && (req_len <= 9'd256)));
  assign req_writes = (req_op >= 3'd1) && (req_op <= 3'd4);
  assign is_erase   = (op_q == OP_SE) || (op_q == OP_BE32) || (op_q == OP_BE64);
  assign is_read    = (op_q == OP_READ) || (op_q == OP_RDSR);

  // State and registered outputs; ncs goes high the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      poll_q     <= '0;
      pend_q     <= 1'b0;
      ncs_q      <= 1'b1;
      start_q    <= 1'b0;
      tx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      poll_q     <= poll_d;
      pend_q     <= pend_d;
      ncs_q      <= ncs_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state, byte issue and handshake decode for the whole transaction.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    poll_d     = poll_q;
    pend_d     = pend_q;
    ncs_d      = ncs_q;
    start_d    = 1'b0;
    tx_d       = tx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    wr_ready   = 1'b0;

    if (can_issue) begin
      if (state_q == S_DATA && op_q == OP_PROG) begin
        // Program data stalls here indefinitely until the host offers a byte.
        if (wr_valid) begin
          wr_ready = 1'b1;
          tx_d     = wr_data;
          start_d  = 1'b1;
          pend_d   = 1'b1;
        end
      end else begin
        start_d = 1'b1;
        pend_d  = 1'b1;
        case (state_q)
          S_WREN:     tx_d = 8'h06;
          S_CMD:      tx_d = opcode(op_q);
          S_ADDR:     tx_d = (cnt_q[1:0] == 2'd0) ? addr_q[23:16] :
                             (cnt_q[1:0] == 2'd1) ? addr_q[15:8] : addr_q[7:0];
          S_POLL_CMD: tx_d = 8'h05;
          default:    tx_d = 8'h00;
        endcase
      end
    end

    if (xfer_done) pend_d = 1'b0;

    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d   = op_e'(req_op);
        addr_d = req_addr;
        len_d  = req_len;
        cnt_d  = '0;
        gap_d  = '0;
        poll_d = '0;
        if (!req_legal) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b0;
          ncs_d   = 1'b0;
          state_d = req_writes ? S_WREN : S_CMD;
        end
      end
      S_WREN: if (xfer_done) begin
        ncs_d   = 1'b1;
        gap_d   = '0;
        state_d = S_WREN_GAP;
      end
      S_WREN_GAP: if (gap_q == CS_LAST) begin
        ncs_d   = 1'b0;
        state_d = S_CMD;
      end else gap_d = gap_q + 16'd1;
      S_CMD: if (xfer_done) begin
        cnt_d = '0;
        if (op_q == OP_RDSR) begin
          len_d   = 9'd1;
          state_d = S_DATA;
        end else state_d = S_ADDR;
      end
      S_ADDR: if (xfer_done) begin
        if (cnt_q == 9'd2) begin
          cnt_d = '0;
          if (is_erase) begin
            ncs_d   = 1'b1;
            gap_d   = '0;
            state_d = S_END_GAP;
          end else state_d = S_DATA;
        end else cnt_d = cnt_q + 9'd1;
      end
      S_DATA: if (xfer_done) begin
        if (op_q != OP_PROG) begin
          rd_data_d  = shf_rx;
          rd_valid_d = 1'b1;
        end
        cnt_d = cnt_q + 9'd1;
        if (cnt_q + 9'd1 == len_q) begin
          ncs_d   = 1'b1;
          gap_d   = '0;
          state_d = S_END_GAP;
        end
      end
      S_END_GAP: if (gap_q == CS_LAST) begin
        gap_d = '0;
        if (is_read) state_d = S_DONE;
        else begin
          ncs_d   = 1'b0;
          state_d = S_POLL_CMD;
        end
      end else gap_d = gap_q + 16'd1;
      S_POLL_CMD: if (xfer_done) state_d = S_POLL_RD;
      S_POLL_RD: if (xfer_done) begin
        ncs_d  = 1'b1;
        poll_d = poll_q + 16'd1;
        gap_d  = '0;
        if (!shf_rx[0]) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (poll_q + 16'd1 == POLL_LIM) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: if (gap_q == POLL_LAST) begin
        gap_d   = '0;
        ncs_d   = 1'b0;
        state_d = S_POLL_CMD;
      end else gap_d = gap_q + 16'd1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign ncs       = ncs_q;
  assign shf_start = start_q;
  assign shf_tx    = tx_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
